// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Shares the ID-stage register-file write port between the core writeback
// path (WB) and a FIFO-buffered late-return path (LD). Register 0 is never
// written. Reports read hazards for two decoder source registers.
//
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   wb_valid/addr/data        writeback request; wb_ready acknowledges it
//   ld_valid/addr/data        late-return request; ld_ready accepts into FIFO
//   rs_addr, rt_addr          decoder source registers to check
//   hazard_rs, hazard_rt      a write to that register is still pending
//   rf_we/rf_waddr/rf_wdata   registered register-file write port
//   fifo_count                LD entries currently buffered
module rf_write_arbiter #(
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          wb_valid,
   input  logic [4:0]                    wb_addr,
   input  logic [31:0]                   wb_data,
   output logic                          wb_ready,
   input  logic                          ld_valid,
   input  logic [4:0]                    ld_addr,
   input  logic [31:0]                   ld_data,
   output logic                          ld_ready,
   input  logic [4:0]                    rs_addr,
   input  logic [4:0]                    rt_addr,
   output logic                          hazard_rs,
   output logic                          hazard_rt,
   output logic                          rf_we,
   output logic [4:0]                    rf_waddr,
   output logic [31:0]                   rf_wdata,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GRANT_WB = 2'd1,
      GRANT_LD = 2'd2,
      FORCE_LD = 2'd3
   } state_t;

   state_t              state;
   state_t              next_state;
   logic [PTR_W-1:0]    rd_ptr;
   logic [PTR_W-1:0]    wr_ptr;
   logic [STV_W-1:0]    starve_cnt;
   logic [4:0]          mem_addr [FIFO_DEPTH];
   logic [31:0]         mem_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] entry_valid;

   logic fifo_empty;
   logic force_ld;
   logic wb_req;
   logic push;
   logic pop;

   assign fifo_empty = (fifo_count == CNT_W'(0));
   assign force_ld   = (starve_cnt == STV_W'(STARVE_LIMIT)) && !fifo_empty;
   assign wb_req     = wb_valid && (wb_addr != 5'd0);

   // WB is only refused when the starved LD head is being forced through.
   assign wb_ready = !force_ld;
   assign ld_ready = (fifo_count < CNT_W'(FIFO_DEPTH)) && !RST;
   // Address-0 LD transfers complete the handshake but are dropped here.
   assign push     = ld_valid && ld_ready && (ld_addr != 5'd0);
   assign pop      = (next_state == GRANT_LD) || (next_state == FORCE_LD);

   // A write is presented to the register file in every non-idle state.
   assign rf_we = (state != IDLE);

   // Grant selection for this cycle
   always_comb begin
      next_state = IDLE;
      if (force_ld)
         next_state = FORCE_LD;
      else if (wb_req)
         next_state = GRANT_WB;
      else if (!fifo_empty)
         next_state = GRANT_LD;
   end

   // State, output stage, FIFO pointers/count and starvation counter
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         rf_waddr   <= 5'd0;
         rf_wdata   <= 32'd0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
         starve_cnt <= '0;
      end else begin
         state <= next_state;

         case (next_state)
            GRANT_WB: begin
               rf_waddr <= wb_addr;
               rf_wdata <= wb_data;
            end
            GRANT_LD, FORCE_LD: begin
               rf_waddr <= mem_addr[rd_ptr];
               rf_wdata <= mem_data[rd_ptr];
            end
            default: ;
         endcase

         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);

         if (push && !pop)
            fifo_count <= fifo_count + CNT_W'(1);
         else if (pop && !push)
            fifo_count <= fifo_count - CNT_W'(1);

         // Counts WB grants that bypassed a waiting LD head.
         if (pop || fifo_empty)
            starve_cnt <= '0;
         else if ((next_state == GRANT_WB) && (starve_cnt != STV_W'(STARVE_LIMIT)))
            starve_cnt <= starve_cnt + STV_W'(1);
      end
   end

   // FIFO storage; validity is tracked by pointers and count, so no reset
   always_ff @(posedge CLK) begin
      if (push) begin
         mem_addr[wr_ptr] <= ld_addr;
         mem_data[wr_ptr] <= ld_data;
      end
   end

   // Hazard detection from registered state only
   always_comb begin
      hazard_rs = 1'b0;
      hazard_rt = 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
         // Entry i is live when its distance from the read pointer is below count.
         entry_valid[i] = (CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr)) < fifo_count);
         if (entry_valid[i] && (mem_addr[i] == rs_addr))
            hazard_rs = 1'b1;
         if (entry_valid[i] && (mem_addr[i] == rt_addr))
            hazard_rt = 1'b1;
      end
      if (rf_we && (rf_waddr == rs_addr))
         hazard_rs = 1'b1;
      if (rf_we && (rf_waddr == rt_addr))
         hazard_rt = 1'b1;
      if (rs_addr == 5'd0)
         hazard_rs = 1'b0;
      if (rt_addr == 5'd0)
         hazard_rt = 1'b0;
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed testbench for rf_write_arbiter with hand-computed expectations.
module tb_rf_write_arbiter;

   logic        CLK;
   logic        RST;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        wb_ready;
   logic        ld_valid;
   logic [4:0]  ld_addr;
   logic [31:0] ld_data;
   logic        ld_ready;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic        hazard_rs;
   logic        hazard_rt;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [2:0]  fifo_count;

   int errors = 0;
   int checks = 0;

   rf_write_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .wb_valid   (wb_valid),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .wb_ready   (wb_ready),
      .ld_valid   (ld_valid),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .ld_ready   (ld_ready),
      .rs_addr    (rs_addr),
      .rt_addr    (rt_addr),
      .hazard_rs  (hazard_rs),
      .hazard_rt  (hazard_rt),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .fifo_count (fifo_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; land shortly after the rising edge.
   task automatic step;
      @(posedge CLK);
      #2;
   endtask

   logic [31:0] wdat;

   initial begin
      RST = 1'b1;
      wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
      ld_valid = 1'b0; ld_addr = 5'd0; ld_data = 32'd0;
      rs_addr = 5'd0; rt_addr = 5'd0;
      #1;
      check("rst_rf_we",      32'(rf_we),      32'd0);
      check("rst_rf_waddr",   32'(rf_waddr),   32'd0);
      check("rst_rf_wdata",   rf_wdata,        32'd0);
      check("rst_fifo_count", 32'(fifo_count), 32'd0);
      check("rst_ld_ready",   32'(ld_ready),   32'd0);
      check("rst_wb_ready",   32'(wb_ready),   32'd1);
      check("rst_hazard_rs",  32'(hazard_rs),  32'd0);
      step; step;
      RST = 1'b0;
      #1;
      check("rel_ld_ready", 32'(ld_ready), 32'd1);

      // WB into idle arbiter, then a discarded address-0 WB
      wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
      check("wb_ready_idle", 32'(wb_ready), 32'd1);
      step;
      wb_valid = 1'b0;
      check("wb_rf_we",    32'(rf_we),    32'd1);
      check("wb_rf_waddr", 32'(rf_waddr), 32'd5);
      check("wb_rf_wdata", rf_wdata,      32'h1234);
      wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD;
      check("wb0_ready", 32'(wb_ready), 32'd1);
      step;
      wb_valid = 1'b0;
      check("wb0_rf_we",    32'(rf_we),    32'd0);
      check("wb0_hold_addr", 32'(rf_waddr), 32'd5);
      check("wb0_hold_data", rf_wdata,      32'h1234);

      // LD only: hazard from FIFO, then from output stage, then clear
      rs_addr = 5'd9; rt_addr = 5'd0;
      ld_valid = 1'b1; ld_addr = 5'd9; ld_data = 32'hFFFF_FFF7;
      check("ld_ready_idle", 32'(ld_ready), 32'd1);
      step;
      ld_valid = 1'b0;
      #1;
      check("ld_c1_count",  32'(fifo_count), 32'd1);
      check("ld_c1_haz_rs", 32'(hazard_rs),  32'd1);
      check("ld_c1_haz_rt0", 32'(hazard_rt), 32'd0);
      check("ld_c1_rf_we",  32'(rf_we),      32'd0);
      step;
      check("ld_c2_rf_we",    32'(rf_we),      32'd1);
      check("ld_c2_rf_waddr", 32'(rf_waddr),   32'd9);
      check("ld_c2_rf_wdata", rf_wdata,        32'hFFFF_FFF7);
      check("ld_c2_haz_rs",   32'(hazard_rs),  32'd1);
      check("ld_c2_count",    32'(fifo_count), 32'd0);
      step;
      check("ld_c3_rf_we",  32'(rf_we),     32'd0);
      check("ld_c3_haz_rs", 32'(hazard_rs), 32'd0);

      // Fill FIFO behind continuous WB traffic
      wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'h100;
      ld_valid = 1'b1; rs_addr = 5'd23; rt_addr = 5'd25;
      for (int k = 0; k < 4; k++) begin
         ld_addr = 5'(20 + k);
         ld_data = 32'h200 + 32'(k);
         step;
      end
      ld_addr = 5'd24; ld_data = 32'h224;
      wb_valid = 1'b0;
      #1;
      check("full_count",    32'(fifo_count), 32'd4);
      check("full_ld_ready", 32'(ld_ready),   32'd0);
      check("full_haz_rs",   32'(hazard_rs),  32'd1);
      check("full_haz_rt",   32'(hazard_rt),  32'd0);
      check("full_rf_waddr", 32'(rf_waddr),   32'd1);
      step;
      check("pop1_count",    32'(fifo_count), 32'd3);
      check("pop1_addr",     32'(rf_waddr),   32'd20);
      check("pop1_data",     rf_wdata,        32'h200);
      check("pop1_ld_ready", 32'(ld_ready),   32'd1);
      step;
      ld_valid = 1'b0;
      check("pushpop_count", 32'(fifo_count), 32'd3);
      check("pop2_addr",     32'(rf_waddr),   32'd21);
      check("pop2_data",     rf_wdata,        32'h201);
      step;
      check("pop3_addr",  32'(rf_waddr),   32'd22);
      check("pop3_count", 32'(fifo_count), 32'd2);
      step;
      check("pop4_addr",  32'(rf_waddr),   32'd23);
      check("pop4_count", 32'(fifo_count), 32'd1);
      step;
      check("pop5_addr",  32'(rf_waddr),   32'd24);
      check("pop5_data",  rf_wdata,        32'h224);
      check("pop5_count", 32'(fifo_count), 32'd0);
      step;
      check("drain_rf_we", 32'(rf_we), 32'd0);

      // Starvation: one LD entry vs continuous WB
      wdat = 32'd100;
      wb_valid = 1'b1; wb_addr = 5'd2; wb_data = wdat;
      ld_valid = 1'b1; ld_addr = 5'd30; ld_data = 32'hABCD;
      for (int c = 0; c < 11; c++) begin
         check($sformatf("starve_wb_ready_c%0d", c), 32'(wb_ready), (c == 9) ? 32'd0 : 32'd1);
         step;
         ld_valid = 1'b0;
         if (c != 9)
            wdat = wdat + 32'd1;
         wb_data = wdat;
         check($sformatf("starve_we_c%0d", c + 1), 32'(rf_we), 32'd1);
         if (c + 1 == 10) begin
            check("starve_ld_addr", 32'(rf_waddr), 32'd30);
            check("starve_ld_data", rf_wdata,      32'hABCD);
         end else if (c + 1 == 11) begin
            check("starve_held_wb", rf_wdata, 32'd109);
         end else begin
            check($sformatf("starve_wb_data_c%0d", c + 1), rf_wdata, 32'd100 + 32'(c));
         end
      end
      wb_valid = 1'b0;
      step;
      step;
      check("starve_end_rf_we", 32'(rf_we), 32'd0);

      // Same address: WB first, LD value lands last
      rs_addr = 5'd17; rt_addr = 5'd0;
      ld_valid = 1'b1; ld_addr = 5'd17; ld_data = 32'h1111;
      wb_valid = 1'b1; wb_addr = 5'd17; wb_data = 32'h2222;
      step;
      ld_valid = 1'b0; wb_valid = 1'b0;
      check("same_wb_addr", 32'(rf_waddr),   32'd17);
      check("same_wb_data", rf_wdata,        32'h2222);
      check("same_haz",     32'(hazard_rs),  32'd1);
      check("same_count",   32'(fifo_count), 32'd1);
      step;
      check("same_ld_addr", 32'(rf_waddr), 32'd17);
      check("same_ld_data", rf_wdata,      32'h1111);
      step;
      check("same_end_we",  32'(rf_we),     32'd0);
      check("same_end_haz", 32'(hazard_rs), 32'd0);

      // Reset mid-stream with three LD entries queued
      wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
      ld_valid = 1'b1; rs_addr = 5'd11; rt_addr = 5'd12;
      for (int k = 0; k < 3; k++) begin
         ld_addr = 5'(10 + k);
         ld_data = 32'h500 + 32'(k);
         step;
      end
      ld_valid = 1'b0;
      #1;
      check("pre_rst_count", 32'(fifo_count), 32'd3);
      check("pre_rst_haz",   32'(hazard_rs),  32'd1);
      RST = 1'b1; wb_valid = 1'b0;
      #1;
      check("mid_rst_count",  32'(fifo_count), 32'd0);
      check("mid_rst_rf_we",  32'(rf_we),      32'd0);
      check("mid_rst_haz_rs", 32'(hazard_rs),  32'd0);
      check("mid_rst_haz_rt", 32'(hazard_rt),  32'd0);
      check("mid_rst_ld_rdy", 32'(ld_ready),   32'd0);
      step;
      RST = 1'b0;
      #1;
      check("post_rst_ld_ready", 32'(ld_ready),   32'd1);
      check("post_rst_count",    32'(fifo_count), 32'd0);
      step;
      check("post_rst_rf_we", 32'(rf_we), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port of the ID stage between two writers: the core writeback path (WB, normally highest priority) and a late-return requester (LD: multi-cycle load returns or debug/loader writes) buffered in a small FIFO. It drives the register file's write enable, address and data from a registered output stage. It never writes register 0. It flags read hazards so the decoder can stall when a source register still has a write pending.

## Interface
- FIFO_DEPTH, 4, LD buffer entries (power of two, ≥2)
- STARVE_LIMIT, 8, consecutive WB grants with a non-empty FIFO before LD is forced
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- wb_valid  in  1  WB write request this cycle
- wb_addr  in  5  WB destination register
- wb_data  in  32  WB write data
- wb_ready  out  1  WB accepted this cycle; core holds wb_* while low
- ld_valid  in  1  LD write request
- ld_addr  in  5  LD destination register
- ld_data  in  32  LD write data
- ld_ready  out  1  FIFO can accept; transfer when ld_valid && ld_ready
- rs_addr, rt_addr  in  5 each  decoder source registers to check
- hazard_rs, hazard_rt  out  1 each  pending write to that register
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  32  register-file write data (registered)
- fifo_count  out  log2(FIFO_DEPTH)+1  LD entries held

## Operation
- Request qualification: a WB request is wb_valid && wb_addr != 0. WB with addr 0 is accepted (wb_ready=1) and discarded. An LD transfer with ld_addr == 0 completes the handshake and is not enqueued.
- Grant FSM states:
  - IDLE: no write this cycle.
  - GRANT_WB: output stage loads wb_addr/wb_data.
  - GRANT_LD: output stage loads the FIFO head; the head is popped.
  - FORCE_LD: like GRANT_LD, with wb_ready=0.
- Next-state selection, evaluated every cycle:
  - starve_cnt == STARVE_LIMIT and FIFO non-empty → FORCE_LD.
  - Otherwise, qualified WB request → GRANT_WB.
  - Otherwise, FIFO non-empty → GRANT_LD.
  - Otherwise → IDLE.
- wb_ready is 1 in every state except FORCE_LD. A held WB request is granted on the following cycle.
- starve_cnt:
  - +1 on a GRANT_WB cycle while the FIFO is non-empty.
  - Cleared on any LD pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- FIFO:
  - Circular buffer with wrapping read and write pointers and a count.
  - ld_ready = (count < FIFO_DEPTH) && !RST.
  - Push and pop in the same cycle are allowed when not full: count is unchanged and both pointers advance.
  - When full, ld_ready=0 even if a pop occurs that cycle.
- Output stage:
  - rf_we=1 for one cycle per grant; rf_waddr/rf_wdata hold the granted entry.
  - In IDLE: rf_we=0; address and data hold their last values.
- Ordering: writes retire in grant order. The last physical write to a register wins. There is no merging or cancellation of same-address writes.
- Hazard: hazard_rs=1 iff rs_addr != 0 and rs_addr matches any valid FIFO entry or the output stage while rf_we=1. hazard_rt is computed the same way. Both are combinational from registered state only, never from wb_*/ld_* inputs.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, fifo_count=0, ld_ready=0 while RST is high, hazard_*=0, wb_ready=1, FSM=IDLE, starve_cnt=0.
- On RST assertion mid-operation, all FIFO contents are discarded immediately (asynchronously). Any write in flight is dropped.
- WB latency: accepted at edge N → rf_we=1 during cycle N+1.
- LD latency: best case, pushed at edge N and granted at N+1 → rf_we=1 during cycle N+2.
- Worst-case LD wait under continuous WB traffic: STARVE_LIMIT+1 grant cycles from the entry reaching the FIFO head.
- Throughput: one register write per cycle.

## Test plan
- Reset mid-stream: 3 LD entries queued, RST pulsed for 1 cycle → fifo_count=0, rf_we=0, hazard_*=0 with no edge required; ld_ready=1 on the first cycle after release.
- Idle WB: wb_valid=1, addr=5, data=0x1234 at edge 0 → rf_we=1, rf_waddr=5, rf_wdata=0x1234 in cycle 1; wb_addr=0 → rf_we stays 0 and wb_ready=1.
- LD only: push addr=9 data=0xFFFFFFF7 at edge 0 → hazard_rs=1 for rs_addr=9 from cycle 1; rf_we with addr 9 in cycle 2; hazard clears in cycle 3.
- FIFO full: push 4 entries with WB held continuously → ld_ready=0, fifo_count=4; the 5th request waits until a pop; simultaneous push and pop at count=3 leaves count=3.
- Starvation: 1 LD entry plus continuous WB with STARVE_LIMIT=8 → 8 WB writes, then 1 cycle with wb_ready=0 while the LD entry is written, then the held WB is written next.
- Same address: LD to register 17 queued, then WB to 17 granted first → rf_waddr=17 written twice, WB data then LD data (LD value is final).
